router_nch: RTL and testbench

- Parametrised 1-to-NUM_CH packet router; successor to the fixed 3-bit, 3-port router.
- Accepts header/payload/parity packets on one input stream and steers each packet into a per-channel FIFO selected by the header address.
- Checks even parity across the packet and drops packets sent to nonexistent channels.
- Flushes a channel whose consumer stops reading. Sits between the tt_um_* top-level pin mapping and external consumers.

---
 rtl/router_nch.sv | 185 ++++++++++++++++++
 tb/tb_router_nch.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_nch.sv
// Purpose: 1-to-NUM_CH packet router; parses header/payload/parity, steers to per-channel FWFT FIFOs.
// Latency: a word accepted on cycle t is at a channel head on t+1; one busy bubble follows each stored packet.
// Backpressure: busy is raised while the target FIFO is full or during the parity check bubble; stalled channels self-flush after TIMEOUT.
module router_nch #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int NUM_CH  = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pkt_valid,
    input  logic [NUM_CH-1:0]        read_enb,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        vld_out,
    output logic                     err,
    output logic                     busy,
    output logic                     drop
);

    localparam int LEN_W = DATA_W - ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PARITY = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] dest_q;
    logic [ADDR_W-1:0] tgt;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  hdr_len;
    logic [DATA_W-1:0] parity_acc;

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] rd;
    logic [NUM_CH-1:0] flush;

    logic in_write_state;
    logic hdr_ok;
    logic xfer;
    logic wr_en;

    assign hdr_len = data_in[DATA_W-1:ADDR_W];

    // In IDLE the incoming header decides the target; afterwards the latched dest does.
    assign tgt = (state == S_IDLE) ? data_in[ADDR_W-1:0] : dest_q;

    // One-hot channel select; an out-of-range address selects nothing, so it can never look full.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_sel
        assign sel[k] = (tgt == ADDR_W'(k));
    end

    assign hdr_ok         = (sel != '0);
    assign in_write_state = (state == S_IDLE) || (state == S_LOAD) || (state == S_PARITY);

    // A full target blocks the word even if the consumer pops it on the same edge.
    assign busy  = (state == S_CHECK) ||
                   (pkt_valid && in_write_state && ((sel & full) != '0));
    assign xfer  = pkt_valid && !busy;
    assign wr_en = xfer && (((state == S_IDLE) && hdr_ok) ||
                            (state == S_LOAD) || (state == S_PARITY));
    assign drop  = (state == S_DROP) && xfer && (remaining == '0);

    // Packet parser: header latch, payload countdown, parity compare, discard of bad addresses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            dest_q     <= '0;
            remaining  <= '0;
            parity_acc <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        dest_q    <= data_in[ADDR_W-1:0];
                        remaining <= hdr_len;
                        if (!hdr_ok) begin
                            state <= S_DROP;
                        end else begin
                            err        <= 1'b0;
                            parity_acc <= data_in;
                            state      <= (hdr_len == '0) ? S_PARITY : S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        parity_acc <= parity_acc ^ data_in;
                        remaining  <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    // The compare result goes straight into err so it is already
                    // visible during the CHECK bubble and held until the next good header.
                    if (xfer) begin
                        err   <= (parity_acc != data_in);
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state <= S_IDLE;
                end
                S_DROP: begin
                    if (xfer) begin
                        if (remaining == '0) begin
                            state <= S_IDLE;
                        end else begin
                            remaining <= remaining - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wp;
        logic [PTR_W-1:0]  rp;
        logic [CNT_W-1:0]  cnt;
        logic [TMO_W-1:0]  tmo;

        assign full[k]    = (cnt == CNT_W'(DEPTH));
        assign vld_out[k] = (cnt != '0);
        assign rd[k]      = read_enb[k] && vld_out[k];
        // Flush fires on the edge where the unread streak would reach TIMEOUT.
        assign flush[k]   = vld_out[k] && !read_enb[k] && (tmo == TMO_W'(TIMEOUT - 1));
        // A word landing on the flush edge is lost; the rest of its packet still lands.
        assign wr[k]      = wr_en && sel[k] && !flush[k];

        assign data_out[k*DATA_W +: DATA_W] = vld_out[k] ? mem[rp] : '0;

        // Storage array; contents are only observable while cnt is non-zero, so no reset.
        always_ff @(posedge clock) begin
            if (wr[k]) begin
                mem[wp] <= data_in;
            end
        end

        // Pointer and occupancy bookkeeping; flush behaves as a per-channel soft reset.
        always_ff @(posedge clock) begin
            if (reset || flush[k]) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp <= wp + PTR_W'(wr[k]);
                rp <= rp + PTR_W'(rd[k]);
                case ({wr[k], rd[k]})
                    2'b10:   cnt <= cnt + CNT_W'(1);
                    2'b01:   cnt <= cnt - CNT_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        // Unread-cycle counter: runs while the head sits unread, restarts on any pop or when empty.
        always_ff @(posedge clock) begin
            if (reset || flush[k]) begin
                tmo <= '0;
            end else if (vld_out[k] && !read_enb[k]) begin
                tmo <= tmo + TMO_W'(1);
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_router_nch.sv
// Bench for router_nch: directed scenarios followed by random packets.
// Reference model tracks each packet by word position and each channel as a queue plus an unread age.
// Monitor pops expected words whenever the DUT presents a read head word.
module tb_router_nch;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NC = 3;
    localparam int DP = 4;
    localparam int TO = 30;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [DW-1:0]    data_in = '0;
    logic             pkt_valid = 1'b0;
    logic [NC-1:0]    read_enb = '0;
    logic [NC*DW-1:0] data_out;
    logic [NC-1:0]    vld_out;
    logic             err;
    logic             busy;
    logic             drop;

    router_nch #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .DEPTH(DP), .TIMEOUT(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .pkt_valid(pkt_valid),
        .read_enb (read_enb),
        .data_out (data_out),
        .vld_out  (vld_out),
        .err      (err),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // scoreboard and model state
    logic [DW-1:0] exp_q [NC][$];
    int            occ  [NC];
    int            age  [NC];
    int            pos = 0;        // words of current packet already taken (0 = expecting header)
    int            plen = 0;
    int            pdest = 0;
    logic [DW-1:0] acc = '0;
    logic          stall = 1'b0;   // check bubble owed after a stored packet
    logic          exp_err = 1'b0;

    int            rd_prob [NC];
    logic [NC-1:0] rd_pulse = '0;
    int            pops [NC];
    int            drop_seen = 0;
    int            vld0_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present one word, optionally after a few idle cycles, and hold it until accepted.
    task automatic send_word(input logic [DW-1:0] w, input int gap);
        int  n;
        bit  taken;
        repeat ($urandom_range(0, gap)) begin
            pkt_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        data_in   = w;
        pkt_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            taken = !busy;
            @(posedge clock);
            #1;
            if (taken) break;
            n++;
            if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL send_word: busy held for %0d cycles, expected release", n);
                break;
            end
        end
        pkt_valid = 1'b0;
    endtask

    task automatic send_pkt(input int dest, input int len, input bit bad, input int gap);
        logic [DW-1:0] hdr;
        logic [DW-1:0] par;
        logic [DW-1:0] w;
        hdr = DW'((len << AW) | dest);
        par = hdr;
        send_word(hdr, gap);
        for (int i = 0; i < len; i++) begin
            w   = DW'($urandom);
            par = par ^ w;
            send_word(w, gap);
        end
        if (bad) par = par ^ DW'($urandom_range(1, 255));
        send_word(par, gap);
    endtask

    // consumer: random pops per channel plus directed single pulses
    always begin
        @(posedge clock);
        #2;
        for (int k = 0; k < NC; k++)
            read_enb[k] = (int'($urandom_range(0, 99)) < rd_prob[k]) || rd_pulse[k];
    end

    // reference model: predicts busy/drop for this cycle, then applies the clock edge
    always @(negedge clock) begin : model
        int            tgt;
        bit            tgt_ok;
        bit            eb;
        bit            x;
        bit            dropping;
        bit            last;
        logic [NC-1:0] fl;
        logic [NC-1:0] v;
        #1;
        if (reset) begin
            pos = 0;
            stall = 1'b0;
            exp_err = 1'b0;
            for (int k = 0; k < NC; k++) begin
                occ[k] = 0;
                age[k] = 0;
                exp_q[k].delete();
            end
        end else begin
            tgt    = (pos == 0) ? int'(data_in[AW-1:0]) : pdest;
            tgt_ok = (tgt < NC);
            eb     = stall;
            if (pkt_valid && tgt_ok && !stall) begin
                if (occ[tgt] == DP) eb = 1'b1;
            end
            chk("busy", 32'(busy), 32'(eb));
            x        = pkt_valid && !eb;
            dropping = !tgt_ok;
            last     = (pos != 0) && (pos == plen + 1);
            chk("drop", 32'(drop), 32'(x && dropping && last));
            stall = 1'b0;

            for (int k = 0; k < NC; k++) begin
                v[k]  = (occ[k] > 0);
                fl[k] = v[k] && !read_enb[k] && (age[k] == TO - 1);
                if (fl[k]) begin
                    occ[k] = 0;
                    age[k] = 0;
                    exp_q[k].delete();
                end else begin
                    if (read_enb[k] && v[k]) occ[k]--;
                    age[k] = (v[k] && !read_enb[k]) ? age[k] + 1 : 0;
                end
            end

            if (x) begin
                if (tgt_ok && !fl[tgt]) begin
                    exp_q[tgt].push_back(data_in);
                    occ[tgt]++;
                end
                if (pos == 0) begin
                    pdest = int'(data_in[AW-1:0]);
                    plen  = int'(data_in[DW-1:AW]);
                    acc   = data_in;
                    if (tgt_ok) exp_err = 1'b0;
                    pos = 1;
                end else if (last) begin
                    if (tgt_ok) begin
                        exp_err = (acc != data_in);
                        stall   = 1'b1;
                    end
                    pos = 0;
                end else begin
                    acc = acc ^ data_in;
                    pos++;
                end
            end
        end
    end

    // monitor: compares every presented head word against the scoreboard
    always @(negedge clock) begin : monitor
        logic [DW-1:0] w;
        if (!reset) begin
            for (int k = 0; k < NC; k++) begin
                w = data_out[k*DW +: DW];
                chk($sformatf("vld_out[%0d]", k), 32'(vld_out[k]), 32'(exp_q[k].size() != 0));
                if (vld_out[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL data_out[%0d]: got 0x%0h, expected no word", k, w);
                    end else begin
                        chk($sformatf("data_out[%0d]", k), 32'(w), 32'(exp_q[k][0]));
                        if (read_enb[k]) begin
                            void'(exp_q[k].pop_front());
                            pops[k]++;
                        end
                    end
                end else begin
                    chk($sformatf("data_out[%0d] empty", k), 32'(w), 32'h0);
                end
            end
            chk("err", 32'(err), 32'(exp_err));
            if (drop) drop_seen++;
            if (vld_out[0]) vld0_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int d;
        logic [DW-1:0] par;
        for (int k = 0; k < NC; k++) begin
            rd_prob[k] = 0;
            pops[k] = 0;
        end

        // reset state
        idle(3);
        reset = 1'b0;
        @(negedge clock);
        chk("reset vld_out", 32'(vld_out), 32'h0);
        chk("reset data_out", 32'(data_out), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset drop", 32'(drop), 32'h0);
        @(posedge clock);
        #1;

        // dest 1, L=3, correct parity (0x0D^0x11^0x22^0x33 = 0x0D)
        par = 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33;
        rd_prob[1] = 100;
        p = pops[1];
        send_word(8'h0D, 0); send_word(8'h11, 0); send_word(8'h22, 0);
        send_word(8'h33, 0); send_word(par, 0);
        idle(4);
        chk("good pkt err", 32'(err), 32'h0);
        chk("good pkt words", 32'(pops[1] - p), 32'd5);

        // same packet with wrong parity
        send_word(8'h0D, 0); send_word(8'h11, 0); send_word(8'h22, 0);
        send_word(8'h33, 0); send_word(8'h00, 0);
        idle(3);
        chk("bad parity err", 32'(err), 32'h1);

        // dest 3 is out of range: discarded, err kept, one drop pulse
        d = drop_seen;
        send_word(8'h0B, 1); send_word(8'hA5, 1); send_word(8'h5A, 1); send_word(8'h0B ^ 8'hA5 ^ 8'h5A, 1);
        idle(3);
        chk("drop pulses", 32'(drop_seen - d), 32'd1);
        chk("err kept over drop", 32'(err), 32'h1);
        rd_prob[0] = 100;
        p = pops[0];
        send_pkt(0, 1, 0, 0);
        idle(4);
        chk("err cleared", 32'(err), 32'h0);
        chk("dest0 words", 32'(pops[0] - p), 32'd3);

        // fill a DEPTH=4 channel with a 6-word packet, release one word at a time
        p = pops[2];
        fork
            send_pkt(2, 4, 0, 0);
            begin
                idle(8);
                @(negedge clock);
                chk("full busy", 32'(busy), 32'h1);
                @(posedge clock);
                #1;
                idle(3);
                rd_pulse[2] = 1'b1;
                idle(1);
                rd_pulse[2] = 1'b0;
                idle(5);
                rd_prob[2] = 100;
            end
        join
        idle(8);
        chk("full chan words", 32'(pops[2] - p), 32'd6);

        // header-only packet never read: visible for exactly TIMEOUT cycles
        rd_prob[0] = 0;
        idle(2);
        d = vld0_cnt;
        send_word(8'h00, 0); send_word(8'h00, 0);
        idle(40);
        chk("timeout vld cycles", 32'(vld0_cnt - d), 32'(TO));
        @(negedge clock);
        chk("timeout flushed", 32'(vld_out[0]), 32'h0);
        @(posedge clock);
        #1;

        // reset in the middle of a payload
        rd_prob[1] = 0;
        send_word(8'h0D, 0); send_word(8'h11, 0); send_word(8'h22, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clock);
        chk("mid reset vld_out", 32'(vld_out), 32'h0);
        chk("mid reset data_out", 32'(data_out), 32'h0);
        chk("mid reset busy", 32'(busy), 32'h0);
        chk("mid reset err", 32'(err), 32'h0);
        @(posedge clock);
        #1;
        rd_prob[1] = 100;
        p = pops[1];
        send_word(8'h0D, 0); send_word(8'h11, 0); send_word(8'h22, 0);
        send_word(8'h33, 0); send_word(par, 0);
        idle(4);
        chk("after reset words", 32'(pops[1] - p), 32'd5);

        // random traffic, including bad addresses, bad parity and stalled consumers
        for (int i = 0; i < 150; i++) begin
            if (i % 10 == 0) begin
                for (int k = 0; k < NC; k++) begin
                    case ($urandom_range(0, 3))
                        0: rd_prob[k] = 0;
                        1: rd_prob[k] = 30;
                        2: rd_prob[k] = 70;
                        default: rd_prob[k] = 100;
                    endcase
                end
            end
            send_pkt(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                     ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
        end

        // drain
        for (int k = 0; k < NC; k++) rd_prob[k] = 100;
        idle(40);
        for (int k = 0; k < NC; k++)
            chk($sformatf("drained[%0d]", k), 32'(exp_q[k].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
